// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter that shares one SDRAM port between two block requesters and
// runs a full BURST_LEN-word burst per grant using a setup/strobe/recover word cycle.
module sdram_port_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 32,
    parameter int STRB_CYC   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    // reqN_valid is a level request held until the one-cycle reqN_grant; it is only
    // looked at in IDLE, so dropping it after the grant never aborts the burst.
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic                  req0_wr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_grant,
    output logic                  req0_wnext,
    output logic                  req0_rvalid,
    output logic                  req0_done,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic                  req1_wr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_grant,
    output logic                  req1_wnext,
    output logic                  req1_rvalid,
    output logic                  req1_done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] Address_sdram,
    output logic                  wr_rd_sdram,
    output logic                  mstrb_sdram,
    output logic [DATA_WIDTH-1:0] DOut_sdram,
    input  logic [DATA_WIDTH-1:0] DIn_sdram,
    output logic [2:0]            dbg_state
);
    localparam int OFS = $clog2(BURST_LEN);
    localparam int SCW = (STRB_CYC > 1) ? $clog2(STRB_CYC) : 1;
    localparam int BW  = ADDR_WIDTH - OFS;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STROBE  = 3'd2,
        S_RECOVER = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  ptr_q, ptr_d;
    logic                  wr_q, wr_d;
    logic [BW-1:0]         base_q, base_d;
    logic [OFS-1:0]        word_cnt_q, word_cnt_d;
    logic [SCW-1:0]        strb_cnt_q, strb_cnt_d;
    logic [1:0]            grant_q, grant_d;
    logic [1:0]            wnext_q, wnext_d;
    logic [1:0]            rvalid_q, rvalid_d;
    logic [1:0]            done_q, done_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  busy_q, busy_d;
    logic                  mstrb_q, mstrb_d;
    logic [1:0]            valid;
    logic                  unused_addr_bits;

    assign valid            = {req1_valid, req0_valid};
    // Word offset bits of the request address are replaced by word_cnt.
    assign unused_addr_bits = ^{req0_addr[OFS-1:0], req1_addr[OFS-1:0]};

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        wr_d       = wr_q;
        base_d     = base_q;
        word_cnt_d = word_cnt_q;
        strb_cnt_d = strb_cnt_q;
        rdata_d    = rdata_q;
        dout_d     = dout_q;
        addr_d     = addr_q;
        grant_d    = '0;
        wnext_d    = '0;
        rvalid_d   = '0;
        done_d     = '0;
        unique case (state_q)
            S_IDLE: begin
                if (|valid) begin
                    owner_d          = valid[ptr_q] ? ptr_q : ~ptr_q;
                    base_d           = owner_d ? req1_addr[ADDR_WIDTH-1:OFS]
                                               : req0_addr[ADDR_WIDTH-1:OFS];
                    wr_d             = owner_d ? req1_wr : req0_wr;
                    word_cnt_d       = '0;
                    grant_d[owner_d] = 1'b1;
                    state_d          = S_SETUP;
                end
            end
            S_SETUP: begin
                if (wr_q) begin
                    dout_d = owner_q ? req1_wdata : req0_wdata;
                end
                strb_cnt_d = '0;
                state_d    = S_STROBE;
            end
            S_STROBE: begin
                if (strb_cnt_q == SCW'(STRB_CYC - 1)) begin
                    if (!wr_q) begin
                        rdata_d           = DIn_sdram;
                        rvalid_d[owner_q] = 1'b1;
                    end
                    state_d = S_RECOVER;
                end else begin
                    strb_cnt_d = strb_cnt_q + SCW'(1);
                end
            end
            S_RECOVER: begin
                if (word_cnt_q == '1) begin
                    done_d[owner_q] = 1'b1;
                    state_d         = S_DONE;
                end else begin
                    word_cnt_d = word_cnt_q + OFS'(1);
                    state_d    = S_SETUP;
                end
            end
            S_DONE: begin
                ptr_d   = ~owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Address and wnext are launched together with every entry into SETUP.
        if (state_d == S_SETUP) begin
            addr_d           = {base_d, word_cnt_d};
            wnext_d[owner_d] = wr_d;
        end
        mstrb_d = (state_d == S_STROBE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            ptr_q      <= 1'b0;
            wr_q       <= 1'b0;
            base_q     <= '0;
            word_cnt_q <= '0;
            strb_cnt_q <= '0;
            grant_q    <= '0;
            wnext_q    <= '0;
            rvalid_q   <= '0;
            done_q     <= '0;
            rdata_q    <= '0;
            dout_q     <= '0;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            mstrb_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            wr_q       <= wr_d;
            base_q     <= base_d;
            word_cnt_q <= word_cnt_d;
            strb_cnt_q <= strb_cnt_d;
            grant_q    <= grant_d;
            wnext_q    <= wnext_d;
            rvalid_q   <= rvalid_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            dout_q     <= dout_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            mstrb_q    <= mstrb_d;
        end
    end

    assign req0_grant    = grant_q[0];
    assign req1_grant    = grant_q[1];
    assign req0_wnext    = wnext_q[0];
    assign req1_wnext    = wnext_q[1];
    assign req0_rvalid   = rvalid_q[0];
    assign req1_rvalid   = rvalid_q[1];
    assign req0_done     = done_q[0];
    assign req1_done     = done_q[1];
    assign rdata         = rdata_q;
    assign busy          = busy_q;
    assign Address_sdram = addr_q;
    assign wr_rd_sdram   = wr_q;
    assign mstrb_sdram   = mstrb_q;
    assign DOut_sdram    = dout_q;
    assign dbg_state     = state_q;

endmodule
